// File: rtl/cvita_pkt_pkg.sv
// -----------------------------------------------------------------------------
// cvita_pkt_pkg
// Shared definitions for the CVITA destination demux:
//   - demux FSM state encoding
//   - CVITA beat width and drop counter width
//   - saturating increment helper for the drop counter
// -----------------------------------------------------------------------------
package cvita_pkt_pkg;

    localparam int CVITA_DATA_W = 64;
    localparam int DROP_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DROP  = 2'd2
    } demux_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/cvita_out_reg.sv
// -----------------------------------------------------------------------------
// cvita_out_reg
// Single registered output stage shared by all demux ports. Holds one beat,
// the port it targets (out_sel) and a valid flag, and reports whether it can
// take a new beat this cycle.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   load            load a new beat this cycle (only asserted while ready=1)
//   load_sel        destination port of the beat being loaded
//   load_data/last  beat payload and last flag
//   ready           register empty, or its beat drains this cycle
//   o_tdata/o_tlast shared output payload
//   o_tvalid        per-port valid, one-hot or zero
//   o_tready        per-port ready
// -----------------------------------------------------------------------------
module cvita_out_reg
    import cvita_pkt_pkg::*;
#(
    parameter int NUM_OUTPUTS = 4,
    parameter int DEST_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [DEST_WIDTH-1:0]   load_sel,
    input  logic [CVITA_DATA_W-1:0] load_data,
    input  logic                    load_last,
    output logic                    ready,
    output logic [CVITA_DATA_W-1:0] o_tdata,
    output logic                    o_tlast,
    output logic [NUM_OUTPUTS-1:0]  o_tvalid,
    input  logic [NUM_OUTPUTS-1:0]  o_tready
);

    logic [CVITA_DATA_W-1:0] data_q, data_d;
    logic                    last_q, last_d;
    logic                    out_valid_q, out_valid_d;
    logic [DEST_WIDTH-1:0]   out_sel_q, out_sel_d;
    logic                    sel_tready;

    // Ready of the port currently held in the register. Looping over the
    // ports avoids indexing o_tready with a wider-than-needed selector.
    always_comb begin
        sel_tready = 1'b0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (out_sel_q == DEST_WIDTH'(k)) begin
                sel_tready = o_tready[k];
            end
        end
    end

    // The drain condition uses the port the held beat targets, not the
    // port of the next packet. Across a port change this lets the new
    // packet's first beat load in the same cycle the old last beat leaves,
    // and never overwrites a beat that its own port has not taken yet.
    assign ready = !out_valid_q || sel_tready;

    always_comb begin
        data_d      = data_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            data_d      = load_data;
            last_d      = load_last;
            out_valid_d = 1'b1;
            out_sel_d   = load_sel;
        end else if (sel_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            data_q      <= data_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
        end
    end

    always_comb begin
        o_tvalid = '0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            o_tvalid[k] = out_valid_q && (out_sel_q == DEST_WIDTH'(k));
        end
    end

    assign o_tdata = data_q;
    assign o_tlast = last_q;

endmodule

// File: rtl/cvita_dest_demux.sv
// -----------------------------------------------------------------------------
// cvita_dest_demux
// Routes whole CVITA packets to one of NUM_OUTPUTS AXI-Stream ports using the
// destination looked up for the first beat. Out-of-range destinations are
// swallowed and counted in a saturating drop counter.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | between packets; latch i_tdest of the waiting first beat
//   ST_ROUTE | pass beats into the output register for port sel
//   ST_DROP  | accept and discard beats until i_tlast, then count the drop
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_tdata/i_tlast/i_tvalid/i_tready  input CVITA stream
//   i_tdest                         destination, sampled on first beat only
//   o_tdata/o_tlast                 shared output payload
//   o_tvalid/o_tready               per-port handshake
//   drop_count                      dropped packet count, saturating
// -----------------------------------------------------------------------------
module cvita_dest_demux
    import cvita_pkt_pkg::*;
#(
    parameter int NUM_OUTPUTS = 4,
    parameter int DEST_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CVITA_DATA_W-1:0] i_tdata,
    input  logic                    i_tlast,
    input  logic                    i_tvalid,
    output logic                    i_tready,
    input  logic [DEST_WIDTH-1:0]   i_tdest,
    output logic [CVITA_DATA_W-1:0] o_tdata,
    output logic                    o_tlast,
    output logic [NUM_OUTPUTS-1:0]  o_tvalid,
    input  logic [NUM_OUTPUTS-1:0]  o_tready,
    output logic [DROP_CNT_W-1:0]   drop_count
);

    // One extra bit so NUM_OUTPUTS == 2**DEST_WIDTH still compares correctly.
    localparam logic [DEST_WIDTH:0] NUM_OUT_V = (DEST_WIDTH+1)'(NUM_OUTPUTS);

    demux_state_e            state_q, state_d;
    logic [DEST_WIDTH-1:0]   sel_q, sel_d;
    logic [DROP_CNT_W-1:0]   drop_count_q, drop_count_d;
    logic                    out_ready;
    logic                    load;
    logic                    dest_in_range;

    assign dest_in_range = ({1'b0, i_tdest} < NUM_OUT_V);

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        drop_count_d = drop_count_q;
        i_tready     = 1'b0;
        load         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The first beat is only inspected here; it is consumed
                // in ROUTE/DROP on the following cycle.
                if (i_tvalid) begin
                    sel_d   = i_tdest;
                    state_d = dest_in_range ? ST_ROUTE : ST_DROP;
                end
            end
            ST_ROUTE: begin
                i_tready = out_ready;
                if (i_tvalid && out_ready) begin
                    load = 1'b1;
                    if (i_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                i_tready = 1'b1;
                if (i_tvalid && i_tlast) begin
                    drop_count_d = sat_inc(drop_count_q);
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;

    cvita_out_reg #(
        .NUM_OUTPUTS (NUM_OUTPUTS),
        .DEST_WIDTH  (DEST_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_sel  (sel_q),
        .load_data (i_tdata),
        .load_last (i_tlast),
        .ready     (out_ready),
        .o_tdata   (o_tdata),
        .o_tlast   (o_tlast),
        .o_tvalid  (o_tvalid),
        .o_tready  (o_tready)
    );

endmodule

// File: tb/tb_cvita_dest_demux.sv
module tb_cvita_dest_demux;

    localparam int NO = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   i_tdata;
    logic          i_tlast;
    logic          i_tvalid;
    logic          i_tready;
    logic [DW-1:0] i_tdest;
    logic [63:0]   o_tdata;
    logic          o_tlast;
    logic [NO-1:0] o_tvalid;
    logic [NO-1:0] o_tready;
    logic [15:0]   drop_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] data;
        logic        last;
        int          port;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    bit    mon_en    = 1'b0;
    bit    rand_mode = 1'b0;
    int    any_valid_cycles;
    int    cnt_0100;

    cvita_dest_demux #(.NUM_OUTPUTS(NO), .DEST_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_tdata    (i_tdata),
        .i_tlast    (i_tlast),
        .i_tvalid   (i_tvalid),
        .i_tready   (i_tready),
        .i_tdest    (i_tdest),
        .o_tdata    (o_tdata),
        .o_tlast    (o_tlast),
        .o_tvalid   (o_tvalid),
        .o_tready   (o_tready),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input int pid, input int b);
        return {16'hC0DE, 16'(pid), 16'(b), 16'hBEEF ^ 16'(pid * 7 + b)};
    endfunction

    // Scoreboard: every handshake on any port must match the oldest expected beat.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (o_tvalid != '0) begin
                any_valid_cycles++;
                chk("onehot", 64'($onehot(o_tvalid)), 64'd1);
            end
            if (o_tvalid == 4'b0100) cnt_0100++;
            for (int k = 0; k < NO; k++) begin
                if (o_tvalid[k] && o_tready[k]) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_extra", 64'(k), 64'd99);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("sb_port", 64'(k), 64'(mon_e.port));
                        chk("sb_data", o_tdata, mon_e.data);
                        chk("sb_last", 64'(o_tlast), 64'(mon_e.last));
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) o_tready = 4'($urandom);
        end
    end

    // Called at posedge+1. new_dest >= 0 rewrites i_tdest from beat 1 on.
    task automatic send_pkt(input int dest, input int len, input int pid,
                            input int new_dest, output int stalls);
        beat_t e;
        stalls = 0;
        for (int b = 0; b < len; b++) begin
            int wait_cnt;
            bit acc;
            wait_cnt = 0;
            acc      = 1'b0;
            i_tvalid = 1'b1;
            i_tdata  = mk(pid, b);
            i_tlast  = (b == len - 1);
            i_tdest  = (new_dest >= 0 && b >= 1) ? DW'(new_dest) : DW'(dest);
            if (dest < NO) begin
                e.data = i_tdata;
                e.last = i_tlast;
                e.port = dest;
                exp_q.push_back(e);
            end
            while (!acc && wait_cnt < 200) begin
                @(negedge clk);
                acc = i_tready;
                if (!acc) stalls++;
                @(posedge clk);
                #1;
                wait_cnt++;
            end
            if (!acc) begin
                chk("accept_timeout", 64'd0, 64'd1);
                i_tvalid = 1'b0;
                return;
            end
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_tvalid != '0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        chk("drain_valid", 64'(o_tvalid), 64'd0);
    endtask

    initial begin
        int st;
        int n;
        rst_n    = 1'b0;
        i_tdata  = '0;
        i_tlast  = 1'b0;
        i_tvalid = 1'b0;
        i_tdest  = '0;
        o_tready = '1;
        #1;
        chk("rst_tvalid", 64'(o_tvalid), 64'd0);
        chk("rst_tdata", o_tdata, 64'd0);
        chk("rst_tlast", 64'(o_tlast), 64'd0);
        chk("rst_tready", 64'(i_tready), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Basic route: 4 beats to port 2, one bubble, four 0100 cycles.
        cnt_0100 = 0;
        send_pkt(2, 4, 1, -1, st);
        chk("basic_bubble", 64'(st), 64'd1);
        wait_drain();
        chk("basic_0100_cycles", 64'(cnt_0100), 64'd4);

        // Back-to-back with port 1 stalled while holding its last beat.
        fork
            begin
                send_pkt(1, 3, 2, -1, st);
                send_pkt(3, 2, 3, -1, st);
            end
            begin
                n = 0;
                while (!(o_tvalid[1] && o_tlast) && n < 100) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("b2b_seen_last", 64'(n < 100), 64'd1);
                o_tready[1] = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("b2b_stall", 64'(i_tready), 64'd0);
                    @(posedge clk);
                    #1;
                end
                o_tready = '1;
            end
        join
        wait_drain();

        // Drop path: dest 9, 5 beats.
        any_valid_cycles = 0;
        send_pkt(9, 5, 4, -1, st);
        chk("drop_bubble", 64'(st), 64'd1);
        chk("drop_count1", 64'(drop_count), 64'd1);
        @(posedge clk);
        #1;
        chk("drop_no_valid", 64'(any_valid_cycles), 64'd0);

        force dut.drop_count_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.drop_count_q;
        @(posedge clk);
        #1;
        chk("drop_forced", 64'(drop_count), 64'hFFFF);
        send_pkt(15, 3, 5, -1, st);
        @(posedge clk);
        #1;
        chk("drop_sat", 64'(drop_count), 64'hFFFF);

        // Mid-packet i_tdest rewrite 1 -> 3 must stay on port 1.
        send_pkt(1, 4, 6, 3, st);
        wait_drain();

        // Random backpressure over 1000 packets.
        rand_mode = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            send_pkt($urandom_range(0, NO - 1), $urandom_range(1, 4), 100 + p, -1, st);
        end
        rand_mode = 1'b0;
        @(posedge clk);
        #1;
        o_tready = '1;
        wait_drain();

        // Async reset on beat 3 of a packet to port 0.
        mon_en   = 1'b0;
        i_tvalid = 1'b1;
        i_tdest  = 4'd0;
        i_tlast  = 1'b0;
        i_tdata  = mk(7, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        i_tdata = mk(7, 1);
        @(posedge clk);
        #1;
        i_tdata = mk(7, 2);
        chk("rst_pre_valid", 64'(o_tvalid), 64'd1);
        chk("rst_pre_data", o_tdata, mk(7, 1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("amid_tvalid", 64'(o_tvalid), 64'd0);
        chk("amid_tdata", o_tdata, 64'd0);
        chk("amid_tlast", 64'(o_tlast), 64'd0);
        chk("amid_tready", 64'(i_tready), 64'd0);
        chk("amid_drop", 64'(drop_count), 64'd0);
        i_tvalid = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(0, 3, 8, -1, st);
        chk("post_rst_bubble", 64'(st), 64'd1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
